elpis_uart_tx: RTL

Byte-oriented UART transmitter in the Elpis user project. Core-side writes go into a small FIFO and are serialized as 8N1 frames, LSB first, on a single output wired to mprj_io[6]. The bench's UART receiver decodes these frames, so the core can report test progress and pass/fail without a Wishbone master in the loop.

---
 rtl/elpis_uart_pkg.sv | 33 +++
 rtl/elpis_uart_tx_fifo.sv | 62 ++++++
 rtl/elpis_uart_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/elpis_uart_pkg.sv
// Shared state encoding and frame constants for the Elpis UART transmitter.
// Optional macro ELPIS_UART_TX_PARITY_EN adds an even-parity bit (PARITY state) to every frame.
package elpis_uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef ELPIS_UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

  // Start + data + optional parity + stop, in bit periods.
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

  function automatic int frame_cycles(input int clk_div);
    return FRAME_BITS * clk_div;
  endfunction

endpackage

// File: rtl/elpis_uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; DEPTH must be a power of 2 so pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module elpis_uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds data only; occupancy is tracked by the reset pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/elpis_uart_tx.sv
// Byte-oriented 8N1 UART transmitter with a small transmit FIFO and a registered serial output.
// Optional macro ELPIS_UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module elpis_uart_tx
  import elpis_uart_pkg::*;
#(
  parameter int CLK_DIV    = 347,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wr_valid_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          wr_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   baud_wrap;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [7:0]             fifo_rd_data;

  elpis_uart_tx_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .push_i      (push),
    .push_data_i (wr_data_i),
    .pop_i       (pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_o)
  );

  assign wr_ready_o = !fifo_full;
  assign push       = wr_valid_i && !fifo_full;
  assign busy_o     = (state_q != ST_IDLE) || !fifo_empty;
  assign tx_o       = tx_q;
  assign baud_wrap  = (baud_q == BAUD_LAST);

`ifdef ELPIS_UART_TX_PARITY_EN
  logic parity_q;

  // Even parity is latched at pop time, since the shift register is consumed during DATA.
  always_ff @(posedge wb_clk_i) begin
    if (pop) parity_q <= ^fifo_rd_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;

    if (state_q != ST_IDLE) baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      ST_IDLE:  if (!fifo_empty) pop = 1'b1;
      ST_START: if (baud_wrap) state_d = ST_DATA;
      ST_DATA: begin
        if (baud_wrap) begin
          if (bit_q == BIT_LAST) begin
`ifdef ELPIS_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef ELPIS_UART_TX_PARITY_EN
      ST_PARITY: if (baud_wrap) state_d = ST_STOP;
`endif
      ST_STOP: begin
        if (baud_wrap) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop always starts a fresh frame, whether from IDLE or straight out of STOP.
    if (pop) begin
      state_d = ST_START;
      shift_d = fifo_rd_data;
      bit_d   = '0;
      baud_d  = '0;
    end

    // Line level is decided from the next state so tx_o is a plain flop output.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef ELPIS_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    shift_q <= shift_d;
  end

endmodule
